// File: rtl/sinusoid_pkg.sv
// Shared synth constants for the sine NCO: sample rate, phase step and ROM geometry.
package sinusoid_pkg;

    localparam int unsigned SYS_CLK_HZ  = 100_000_000;
    localparam int unsigned SAMPLE_RATE = 48000;
    localparam int unsigned PHASE_K     = 89478;
    localparam int unsigned LUT_DEPTH   = 256;
    localparam int unsigned LUT_WIDTH   = 15;
    localparam int unsigned LUT_IDX_W   = 8;

    typedef enum logic [1:0] {
        QUAD_0 = 2'd0,
        QUAD_1 = 2'd1,
        QUAD_2 = 2'd2,
        QUAD_3 = 2'd3
    } quadrant_e;

    // Odd quadrants walk the quarter wave backwards.
    function automatic logic [LUT_IDX_W-1:0] fold_index(input quadrant_e q,
                                                       input logic [LUT_IDX_W-1:0] idx);
        return q[0] ? ~idx : idx;
    endfunction

endpackage

// File: rtl/sinusoid_if.sv
// Control/sample bundle between the voice controller and the sine oscillator.
interface sinusoid_if;
    import sinusoid_pkg::*;

    logic        Syn_clk;
    logic        Sin_ce;
    logic [31:0] Freq;
    logic [31:0] Sine_wave;

    modport master (output Syn_clk, output Sin_ce, output Freq, input Sine_wave);
    modport slave  (input Syn_clk, input Sin_ce, input Freq, output Sine_wave);

endinterface

// File: rtl/sinusoid_lut.sv
// Quarter-wave sine magnitude ROM, 256 x 15, contents built at elaboration.
module sinusoid_lut
    import sinusoid_pkg::*;
(
    input  logic [LUT_IDX_W-1:0] i_idx,
    output logic [LUT_WIDTH-1:0] o_mag
);

    localparam real HALF_PI = 1.57079632679489661923;

    logic [LUT_WIDTH-1:0] w_rom [LUT_DEPTH];

    // Half-step sample points keep the table symmetric about the quadrant edges.
    generate
        for (genvar gi = 0; gi < LUT_DEPTH; gi++) begin : g_rom
            localparam real ANG = HALF_PI * (gi + 0.5) / LUT_DEPTH;
            assign w_rom[gi] = LUT_WIDTH'($rtoi(32767.0 * $sin(ANG) + 0.5));
        end
    endgenerate

    assign o_mag = w_rom[i_idx];

endmodule

// File: rtl/sinusoid.sv
// Sine NCO: 32-bit phase accumulator stepped on each enabled sample tick.
module sinusoid
    import sinusoid_pkg::*;
#(
    parameter int unsigned SAMPLE_RATE = sinusoid_pkg::SAMPLE_RATE,
    parameter int unsigned PHASE_K     = 32'(64'd4294967296 / SAMPLE_RATE)
)(
    input  logic       Sys_clk,
    input  logic       Sin_rst,
    sinusoid_if.slave  bus
);

    logic [31:0]          r_phase;
    logic [31:0]          r_inc;
    logic [31:0]          r_sine;

    logic                 w_tick;
    logic [31:0]          w_inc_next;
    quadrant_e            w_quad;
    logic [LUT_IDX_W-1:0] w_idx;
    logic [LUT_WIDTH-1:0] w_mag;
    logic [15:0]          w_s16;

    assign w_tick     = bus.Syn_clk & bus.Sin_ce;
    assign w_inc_next = bus.Freq * PHASE_K;
    assign w_quad     = quadrant_e'(r_phase[31:30]);
    assign w_idx      = fold_index(w_quad, r_phase[29:22]);

    sinusoid_lut u_lut (
        .i_idx (w_idx),
        .o_mag (w_mag)
    );

    // Lower half of the cycle is negated; magnitude never reaches 32768.
    assign w_s16 = w_quad[1] ? -{1'b0, w_mag} : {1'b0, w_mag};

    always_ff @(posedge Sys_clk) begin
        if (Sin_rst) begin
            r_phase <= '0;
            r_inc   <= '0;
            r_sine  <= '0;
        end else begin
            r_inc <= w_inc_next;
            if (w_tick) begin
                r_sine  <= {w_s16, 16'h0000};
                r_phase <= r_phase + r_inc;
            end
        end
    end

    assign bus.Sine_wave = r_sine;

endmodule

// File: tb/tb_sinusoid.sv
// Directed checks of the sine NCO: reset, tick latency, Fs/4 sequence, gating, zero freq.
module tb_sinusoid;

    logic Sys_clk = 1'b0;
    logic Sin_rst;
    int   n_checks = 0;
    int   n_errors = 0;

    sinusoid_if bus ();

    sinusoid dut (
        .Sys_clk (Sys_clk),
        .Sin_rst (Sin_rst),
        .bus     (bus.slave)
    );

    always #5 Sys_clk = ~Sys_clk;

    // Advance one edge; inputs change and outputs are sampled 1 ns after it.
    task automatic step();
        @(posedge Sys_clk);
        #1;
    endtask

    task automatic tick();
        bus.Syn_clk = 1'b1;
        step();
        bus.Syn_clk = 1'b0;
    endtask

    task automatic do_reset(input logic [31:0] freq);
        bus.Freq    = freq;
        bus.Syn_clk = 1'b0;
        Sin_rst     = 1'b1;
        repeat (10) step();
        Sin_rst = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_reset();
        bus.Sin_ce = 1'b1;
        do_reset(32'd1000);
        n_checks++;
        if (bus.Sine_wave !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_value: got %h expected %h", bus.Sine_wave, 32'h0);
        end else $display("reset_value: %h", bus.Sine_wave);
        repeat (5) step();
        n_checks++;
        if (bus.Sine_wave !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_no_tick: got %h expected %h", bus.Sine_wave, 32'h0);
        end else $display("reset_no_tick: %h", bus.Sine_wave);
    endtask

    task automatic test_first_tick();
        bus.Sin_ce = 1'b1;
        do_reset(32'd1000);
        tick();
        n_checks++;
        if (bus.Sine_wave !== 32'h0065_0000) begin
            n_errors++;
            $display("FAIL first_tick: got %h expected %h", bus.Sine_wave, 32'h0065_0000);
        end else $display("first_tick: %h", bus.Sine_wave);
    endtask

    task automatic test_fs4();
        logic [31:0] exp_seq [5];
        exp_seq = '{32'h0065_0000, 32'h7FFF_0000, 32'h0065_0000, 32'h8001_0000, 32'hFF9B_0000};
        bus.Sin_ce = 1'b1;
        do_reset(32'd12000);
        for (int k = 0; k < 5; k++) begin
            tick();
            step();
            n_checks++;
            if (bus.Sine_wave !== exp_seq[k]) begin
                n_errors++;
                $display("FAIL fs4_tick%0d: got %h expected %h", k, bus.Sine_wave, exp_seq[k]);
            end else $display("fs4_tick%0d: %h", k, bus.Sine_wave);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_seq [3];
        exp_seq = '{32'h0065_0000, 32'h7FFF_0000, 32'h0065_0000};
        bus.Sin_ce = 1'b1;
        do_reset(32'd12000);
        bus.Syn_clk = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if (bus.Sine_wave !== exp_seq[k]) begin
                n_errors++;
                $display("FAIL held_tick%0d: got %h expected %h", k, bus.Sine_wave, exp_seq[k]);
            end else $display("held_tick%0d: %h", k, bus.Sine_wave);
        end
        bus.Syn_clk = 1'b0;
        step();
    endtask

    task automatic test_enable_gating();
        bus.Sin_ce = 1'b1;
        do_reset(32'd12000);
        tick();
        step();
        tick();
        step();
        bus.Sin_ce = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            step();
            n_checks++;
            if (bus.Sine_wave !== 32'h7FFF_0000) begin
                n_errors++;
                $display("FAIL gated_hold%0d: got %h expected %h", k, bus.Sine_wave, 32'h7FFF_0000);
            end else $display("gated_hold%0d: %h", k, bus.Sine_wave);
        end
        bus.Sin_ce = 1'b1;
        tick();
        n_checks++;
        if (bus.Sine_wave !== 32'h0065_0000) begin
            n_errors++;
            $display("FAIL resume_tick0: got %h expected %h", bus.Sine_wave, 32'h0065_0000);
        end else $display("resume_tick0: %h", bus.Sine_wave);
        step();
        tick();
        n_checks++;
        if (bus.Sine_wave !== 32'h8001_0000) begin
            n_errors++;
            $display("FAIL resume_tick1: got %h expected %h", bus.Sine_wave, 32'h8001_0000);
        end else $display("resume_tick1: %h", bus.Sine_wave);
    endtask

    task automatic test_zero_freq();
        bus.Sin_ce = 1'b1;
        do_reset(32'd0);
        for (int k = 0; k < 10; k++) begin
            tick();
            step();
            n_checks++;
            if (bus.Sine_wave !== 32'h0065_0000) begin
                n_errors++;
                $display("FAIL zero_freq%0d: got %h expected %h", k, bus.Sine_wave, 32'h0065_0000);
            end else $display("zero_freq%0d: %h", k, bus.Sine_wave);
        end
    endtask

    task automatic test_reset_tick();
        bus.Sin_ce = 1'b1;
        do_reset(32'd12000);
        repeat (3) begin
            tick();
            step();
        end
        Sin_rst     = 1'b1;
        bus.Syn_clk = 1'b1;
        step();
        Sin_rst     = 1'b0;
        bus.Syn_clk = 1'b0;
        n_checks++;
        if (bus.Sine_wave !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_over_tick: got %h expected %h", bus.Sine_wave, 32'h0);
        end else $display("reset_over_tick: %h", bus.Sine_wave);
        repeat (3) step();
        tick();
        n_checks++;
        if (bus.Sine_wave !== 32'h0065_0000) begin
            n_errors++;
            $display("FAIL post_reset_tick0: got %h expected %h", bus.Sine_wave, 32'h0065_0000);
        end else $display("post_reset_tick0: %h", bus.Sine_wave);
        step();
        tick();
        n_checks++;
        if (bus.Sine_wave !== 32'h7FFF_0000) begin
            n_errors++;
            $display("FAIL post_reset_tick1: got %h expected %h", bus.Sine_wave, 32'h7FFF_0000);
        end else $display("post_reset_tick1: %h", bus.Sine_wave);
    endtask

    initial begin
        Sin_rst     = 1'b1;
        bus.Syn_clk = 1'b0;
        bus.Sin_ce  = 1'b0;
        bus.Freq    = 32'd0;
        test_reset();
        test_first_tick();
        test_fs4();
        test_back_to_back();
        test_enable_gating();
        test_zero_freq();
        test_reset_tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sinusoid.md
# sinusoid

Numerically-controlled sine oscillator for the AC97 virtual-analog synth voice path. A 32-bit phase accumulator advances once per audio sample tick by an increment derived from an integer frequency in Hz. The phase is mapped through a quarter-wave sine ROM to a left-justified 32-bit signed sample. The sample tick comes from the sibling block `Synth_clk`, which produces one-cycle pulses at Fs = 48 kHz from the 100 MHz system clock.

## Interface
- `SAMPLE_RATE`, default 48000: sample tick rate in Hz that the increment constant is built for.
- `PHASE_K`, default 89478: phase-increment multiplier, floor(2^32 / SAMPLE_RATE).
- `Sys_clk` input, 1 bit: system clock, 100 MHz. This is the only clock.
- `Sin_rst` input, 1 bit: reset, synchronous and active-high.
- `Syn_clk` input, 1 bit: sample tick. It is a clock enable (one `Sys_clk` cycle per sample), not a clock.
- `Sin_ce` input, 1 bit: oscillator enable.
- `Freq` input, 32 bits: unsigned oscillator frequency in Hz.
- `Sine_wave` output, 32 bits: signed two's-complement sample. Bits [31:16] carry the Q1.15 sine value and bits [15:0] are always 0.

## Operation
- **Increment register:** `inc <= (Freq * PHASE_K) mod 2^32`, updated every `Sys_clk` cycle.
  - No clamp is applied. Frequencies above Fs/2 alias.
- **Tick:** a tick occurs on any cycle where `Syn_clk`=1 and `Sin_ce`=1. If `Syn_clk` is held high for several cycles, each cycle counts as a tick.
- **On each tick**, in the same edge:
  - `Sine_wave <= sine(phase)`.
  - `phase <= phase + inc`, wrapping mod 2^32.
- **Without a tick:** `phase` and `Sine_wave` hold.
- **Sine mapping:**
  - Quadrant q = `phase[31:30]`; index i = `phase[29:22]`.
  - q0: +lut[i]
  - q1: +lut[255-i]
  - q2: −lut[i]
  - q3: −lut[255-i]
- **ROM contents:** lut[n] = round(32767·sin(π/2·(n+0.5)/256)), n = 0..255, unsigned 15-bit.
  - Endpoints: lut[0]=101, lut[255]=32767.
- **Output format:** `Sine_wave = {s16, 16'h0000}`, where s16 is the signed 16-bit result. The range is ±32767, so −32768 never occurs.
- **Priority:** `Sin_rst` > tick > hold.

## Timing
- **Reset** (rising edge of `Sys_clk` with `Sin_rst`=1) clears:
  - `phase` = 0
  - `inc` = 0
  - `Sine_wave` = 0
- **Latency:** `Sine_wave` updates on the edge of the tick cycle and reflects the phase value held *before* that tick.
  - The first tick after reset therefore always outputs sine(0) = 0x0065_0000.
- **Freq changes:** a new value must be stable for ≥2 `Sys_clk` cycles before a tick to be used by that tick. Otherwise it takes effect at the following tick.
- **Reset mid-operation:** reset takes effect at the next edge and overrides a coincident tick. The phase restarts at 0.
- **Freq=0:** the phase is frozen, and `Sine_wave` repeats the sample for the current phase on every tick.
- **Disable:** deasserting `Sin_ce` freezes both `phase` and `Sine_wave`. Re-enabling resumes from the frozen phase with no discontinuity.

## Structure
- **Shared synth package:**
  - `SAMPLE_RATE`, `PHASE_K`
  - `LUT_DEPTH` = 256, `LUT_WIDTH` = 15
  - `SYS_CLK_HZ` = 100_000_000
- **Sub-module `sinusoid_lut`:** combinational 256×15 quarter-wave ROM (case statement or `$readmem` init), index in and magnitude out.
  - Quadrant folding and negation stay in `sinusoid`.
- **`Synth_clk`:** separate block, not part of `sinusoid`. It is a mod-2083 counter on `Sys_clk` giving a one-cycle `Syn_clk` pulse (≈48.008 kHz), with enable `Syn_ce` and synchronous reset `Syn_rst`.

## Test plan
- **Reset:** assert `Sin_rst` for 10 cycles with `Freq`=1000 → `Sine_wave`=0. It stays 0 with `Sin_ce`=1 and no tick.
- **First tick:** after reset, `Freq`=1000, `Sin_ce`=1, one `Syn_clk` pulse → `Sine_wave`=0x0065_0000 one edge later.
- **Fs/4 sequence:** `Freq`=12000 (inc=1_073_736_000), four ticks after reset → 0x0065_0000, 0x7FFF_0000, 0x0065_0000, 0x8001_0000.
- **Enable gating:** `Sin_ce`=0 with 5 `Syn_clk` pulses → output and phase unchanged. Re-enable and tick → sequence continues where it stopped.
- **Zero frequency:** `Freq`=0, 10 ticks after reset → every sample is 0x0065_0000.
- **Reset coincident with tick:** mid-sequence, assert `Sin_rst` in the same cycle as `Syn_clk` → `Sine_wave`=0. The next tick gives 0x0065_0000.
